// File: rtl/fetch_unit.sv
// fetch_unit: fetch-PC generation, in-flight request tracking and a fetch queue that feeds decode
module fetch_unit #(
  parameter int PC_W = 48,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FQ_DEPTH = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] bp_pc,
  input  logic            bp_taken,
  input  logic [PC_W-1:0] bp_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  output logic            dec_pred_taken
);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int QCW = $clog2(FQ_DEPTH + 1);
  localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(MAX_OUT - 1);
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_if_pc [MAX_OUT];
  logic            r_if_tk [MAX_OUT];
  logic [IW-1:0]   r_if_wp, r_if_rp;
  logic [CW-1:0]   r_infl, r_drop;
  logic [31:0]     r_fq_instr [FQ_DEPTH];
  logic [PC_W-1:0] r_fq_pc [FQ_DEPTH];
  logic            r_fq_tk [FQ_DEPTH];
  logic [QW-1:0]   r_fq_wp, r_fq_rp;
  logic [QCW-1:0]  r_fq_cnt;
  logic            w_resp, w_credit, w_fire, w_push, w_pop, w_fq_nz;

  // Responses arriving with nothing outstanding are ignored entirely.
  assign w_resp = imem_resp_valid && (r_infl != '0);
  // Live (non-stale) outstanding requests each hold a reserved queue slot.
  assign w_credit = (32'(r_fq_cnt) + 32'(r_infl) - 32'(r_drop)) < 32'(FQ_DEPTH);
  assign imem_req_valid = n_reset && !redirect_valid && (r_infl < CW'(MAX_OUT)) && w_credit;
  assign w_fire = imem_req_valid && imem_req_ready;
  assign w_push = w_resp && (r_drop == '0) && !redirect_valid;
  assign w_fq_nz = r_fq_cnt != '0;
  assign dec_valid = w_fq_nz && !redirect_valid;
  assign w_pop = dec_valid && dec_ready;
  assign bp_pc = r_pc;
  assign imem_req_addr = r_pc;
  assign dec_instr = w_fq_nz ? r_fq_instr[r_fq_rp] : '0;
  assign dec_pc = w_fq_nz ? r_fq_pc[r_fq_rp] : '0;
  assign dec_pred_taken = w_fq_nz && r_fq_tk[r_fq_rp];

  // Fetch PC: redirect beats prediction, which beats sequential; held while imem stalls.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= redirect_pc & ALIGN;
    else if (w_fire) r_pc <= bp_taken ? (bp_target & ALIGN) : r_pc + PC_W'(4);

  // In-flight bookkeeping; a redirect marks everything still outstanding as stale.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_if_wp <= '0;
      r_if_rp <= '0;
      r_infl <= '0;
      r_drop <= '0;
    end else begin
      if (w_fire) r_if_wp <= (r_if_wp == I_LAST) ? '0 : r_if_wp + IW'(1);
      if (w_resp) r_if_rp <= (r_if_rp == I_LAST) ? '0 : r_if_rp + IW'(1);
      r_infl <= r_infl + CW'(w_fire) - CW'(w_resp);
      if (redirect_valid) r_drop <= r_infl - CW'(w_resp);
      else if (w_resp && r_drop != '0) r_drop <= r_drop - CW'(1);
    end

  // In-flight payload: the PC and prediction of each accepted request.
  always_ff @(posedge clk)
    if (w_fire) begin
      r_if_pc[r_if_wp] <= r_pc;
      r_if_tk[r_if_wp] <= bp_taken;
    end

  // Fetch-queue pointers and occupancy; a redirect flushes the queue.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      r_fq_wp <= '0;
      r_fq_rp <= '0;
      r_fq_cnt <= '0;
    end else if (redirect_valid) begin
      r_fq_wp <= '0;
      r_fq_rp <= '0;
      r_fq_cnt <= '0;
    end else begin
      if (w_push) r_fq_wp <= r_fq_wp + QW'(1);
      if (w_pop) r_fq_rp <= r_fq_rp + QW'(1);
      r_fq_cnt <= r_fq_cnt + QCW'(w_push) - QCW'(w_pop);
    end

  // Fetch-queue payload: instruction paired with the PC and prediction it was fetched under.
  always_ff @(posedge clk)
    if (w_push) begin
      r_fq_instr[r_fq_wp] <= imem_resp_data;
      r_fq_pc[r_fq_wp] <= r_if_pc[r_if_rp];
      r_fq_tk[r_fq_wp] <= r_if_tk[r_if_rp];
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural 1-cycle imem that can hold responses
module tb_fetch_unit;
  localparam int PC_W = 48;
  localparam logic [PC_W-1:0] RST_PC = 48'h1000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            tk;
  } exp_t;

  logic clk = 0, n_reset = 0, redirect_valid = 0, imem_req_ready = 1, imem_resp_valid = 0, dec_ready = 0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic [31:0] imem_resp_data = '0;
  logic bp_taken, imem_req_valid, dec_valid, dec_pred_taken;
  logic [PC_W-1:0] bp_pc, bp_target, imem_req_addr, dec_pc;
  logic [31:0] dec_instr;
  logic bp_en = 0, hold = 0;
  logic [PC_W-1:0] bp_at = '0, bp_tgt = '0;
  exp_t sb[$];
  exp_t mon_e;
  logic [PC_W-1:0] pend[$];
  int n_acc = 0, checks = 0, passed = 0;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RST_PC), .FQ_DEPTH(4), .MAX_OUT(2)) dut (
    .clk(clk), .n_reset(n_reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pred_taken(dec_pred_taken)
  );

  always #5 clk = ~clk;

  assign bp_taken = bp_en && (bp_pc == bp_at);
  assign bp_target = bp_tgt;

  function automatic logic [31:0] instr_of(input logic [PC_W-1:0] a);
    return a[31:0] ^ 32'hA5C3_0013 ^ {16'h0, a[47:32]};
  endfunction

  // imem model: in-order, at least one cycle of latency, responses withheld while hold is set
  always @(negedge clk)
    if (!n_reset) begin
      pend.delete();
      imem_resp_valid = 0;
      imem_resp_data = '0;
    end else begin
      if (!hold && pend.size() > 0) begin
        imem_resp_valid = 1;
        imem_resp_data = instr_of(pend.pop_front());
      end else imem_resp_valid = 0;
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        n_acc++;
      end
    end

  // decode monitor: every handshake must match the next scoreboard entry
  always @(negedge clk)
    if (n_reset && dec_valid && dec_ready) begin
      checks++;
      if (sb.size() == 0) $display("FAIL dec_extra: got pc=%h, expected no decode", dec_pc);
      else begin
        mon_e = sb.pop_front();
        if (dec_pc !== mon_e.pc || dec_instr !== instr_of(mon_e.pc) || dec_pred_taken !== mon_e.tk)
          $display("FAIL dec_entry: got pc=%h instr=%h tk=%b, expected pc=%h instr=%h tk=%b",
                   dec_pc, dec_instr, dec_pred_taken, mon_e.pc, instr_of(mon_e.pc), mon_e.tk);
        else passed++;
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task push_exp(input logic [PC_W-1:0] p, input logic t);
    sb.push_back(exp_t'{pc: p, tk: t});
  endtask

  task do_reset;
    tick();
    n_reset = 0;
    redirect_valid = 0;
    dec_ready = 0;
    imem_req_ready = 1;
    hold = 0;
    bp_en = 0;
    tick();
    tick();
    sb.delete();
    n_acc = 0;
    n_reset = 1;
  endtask

  task wait_empty(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) $display("FAIL drain_timeout: got %0d entries left, expected 0", sb.size());
    else passed++;
    dec_ready = 0;
  endtask

  task test_reset;
    #2;
    checks++;
    if ({imem_req_valid, dec_valid, dec_pred_taken, dec_pc, dec_instr} !== '0)
      $display("FAIL por_outputs: got req=%b dv=%b tk=%b pc=%h instr=%h, expected all 0",
               imem_req_valid, dec_valid, dec_pred_taken, dec_pc, dec_instr);
    else passed++;
    do_reset();
    #2;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL first_req: got v=%b addr=%h, expected v=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    else passed++;
    repeat (4) tick();
    #2;
    checks++;
    if (dec_valid !== 1'b1) $display("FAIL pre_midreset_dv: got %b, expected 1", dec_valid);
    else passed++;
    n_reset = 0;
    #1;
    checks++;
    if ({imem_req_valid, dec_valid, dec_pc, dec_instr} !== '0)
      $display("FAIL midreset_outputs: got req=%b dv=%b pc=%h instr=%h, expected all 0",
               imem_req_valid, dec_valid, dec_pc, dec_instr);
    else passed++;
    tick();
    tick();
    n_reset = 1;
    #2;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
      $display("FAIL post_midreset_req: got v=%b addr=%h, expected v=1 addr=%h", imem_req_valid, imem_req_addr, RST_PC);
    else passed++;
  endtask

  task test_seq_predict;
    logic [PC_W-1:0] ea;
    do_reset();
    bp_en = 1;
    bp_at = 48'h1008;
    bp_tgt = 48'h2003;
    dec_ready = 1;
    push_exp(48'h1000, 0);
    push_exp(48'h1004, 0);
    push_exp(48'h1008, 1);
    push_exp(48'h2000, 0);
    push_exp(48'h2004, 0);
    push_exp(48'h2008, 0);
    for (int i = 0; i < 8; i++) begin
      #2;
      if (i < 5) begin
        ea = (i < 3) ? RST_PC + PC_W'(4 * i) : 48'h2000 + PC_W'(4 * (i - 3));
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== ea)
          $display("FAIL seq_req%0d: got v=%b addr=%h, expected v=1 addr=%h", i, imem_req_valid, imem_req_addr, ea);
        else passed++;
      end
      checks++;
      if (dec_valid !== (i >= 2)) $display("FAIL seq_dv%0d: got %b, expected %b", i, dec_valid, i >= 2);
      else passed++;
      tick();
    end
    dec_ready = 0;
    bp_en = 0;
    checks++;
    if (sb.size() != 0) $display("FAIL seq_left: got %0d entries, expected 0", sb.size());
    else passed++;
  endtask

  task test_redirect;
    do_reset();
    hold = 1;
    dec_ready = 1;
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 48'h5000;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0) $display("FAIL redir_req: got %b, expected 0", imem_req_valid);
    else passed++;
    tick();
    redirect_pc = 48'h6002;
    #2;
    checks++;
    if (dut.r_drop !== 2'd2) $display("FAIL redir_drop1: got %0d, expected 2", dut.r_drop);
    else passed++;
    tick();
    redirect_valid = 0;
    hold = 0;
    #2;
    checks++;
    if (bp_pc !== 48'h6000 || imem_req_addr !== 48'h6000 || dut.r_drop !== 2'd2 || dec_valid !== 1'b0)
      $display("FAIL redir_state: got bp=%h addr=%h drop=%0d dv=%b, expected 6000 6000 2 0",
               bp_pc, imem_req_addr, dut.r_drop, dec_valid);
    else passed++;
    push_exp(48'h6000, 0);
    push_exp(48'h6004, 0);
    push_exp(48'h6008, 0);
    wait_empty(40);
  endtask

  task test_fq_full;
    do_reset();
    repeat (12) tick();
    #2;
    checks++;
    if (n_acc !== 4 || imem_req_valid !== 1'b0)
      $display("FAIL full_issue: got acc=%0d v=%b, expected acc=4 v=0", n_acc, imem_req_valid);
    else passed++;
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== RST_PC)
      $display("FAIL full_head: got dv=%b pc=%h, expected dv=1 pc=%h", dec_valid, dec_pc, RST_PC);
    else passed++;
    for (int i = 0; i < 6; i++) push_exp(RST_PC + PC_W'(4 * i), 0);
    tick();
    dec_ready = 1;
    wait_empty(40);
  endtask

  task test_wrap;
    do_reset();
    imem_req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 48'hFFFF_FFFF_FFFC;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 48'hFFFF_FFFF_FFFC)
        $display("FAIL wrap_hold%0d: got v=%b addr=%h, expected v=1 addr=fffffffffffc", i, imem_req_valid, imem_req_addr);
      else passed++;
      tick();
    end
    imem_req_ready = 1;
    tick();
    #2;
    checks++;
    if (imem_req_addr !== '0) $display("FAIL wrap_next: got %h, expected 0", imem_req_addr);
    else passed++;
    push_exp(48'hFFFF_FFFF_FFFC, 0);
    push_exp(48'h0, 0);
    push_exp(48'h4, 0);
    dec_ready = 1;
    wait_empty(40);
  endtask

  task test_coincident;
    do_reset();
    hold = 1;
    tick();
    tick();
    hold = 0;
    tick();
    hold = 1;
    tick();
    checks++;
    if (dec_valid !== 1'b1) $display("FAIL coin_pre_dv: got %b, expected 1", dec_valid);
    else passed++;
    redirect_valid = 1;
    redirect_pc = 48'h7000;
    dec_ready = 1;
    hold = 0;
    #2;
    checks++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0)
      $display("FAIL coin_cycle: got dv=%b req=%b, expected 0 0", dec_valid, imem_req_valid);
    else passed++;
    tick();
    redirect_valid = 0;
    #2;
    checks++;
    if (dut.r_drop !== 2'd1 || dec_valid !== 1'b0)
      $display("FAIL coin_after: got drop=%0d dv=%b, expected drop=1 dv=0", dut.r_drop, dec_valid);
    else passed++;
    push_exp(48'h7000, 0);
    push_exp(48'h7004, 0);
    wait_empty(40);
  endtask

  initial begin
    test_reset();
    test_seq_predict();
    test_redirect();
    test_fq_full();
    test_wrap();
    test_coincident();
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
